data_mem_responder: RTL
=======================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter MEM_WORDS, default 1024, SHALL be the backing store depth in 32-bit words (power of two).
REQ-002 Parameter QUEUE_DEPTH, default 4, SHALL be the number of accepted-but-unanswered requests (power of two, >=2).
REQ-003 Parameter LATENCY, default 2, SHALL be the service cycles per request at queue head (>=1).
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 data_req  input  1  initiator request valid.
REQ-007 data_wr  input  1  1 = write, 0 = read.
REQ-008 data_wstrb  input  4  byte-lane write enables.
REQ-009 data_addr  input  32  word-aligned byte address.
REQ-010 data_size  input  3  0 byte, 1 half, 2 word; informational only.
REQ-011 data_wdata  input  32  lane-replicated write data.
REQ-012 data_addr_ok  output  1  request accepted this cycle.
REQ-013 data_rdata  output  32  read data, valid with data_data_ok.
REQ-014 data_data_ok  output  1  one-cycle completion pulse, one per accepted request.

Function
REQ-015 A request SHALL be accepted when data_req && data_addr_ok at a rising edge; data_addr_ok SHALL be combinational: data_req && !queue_full && !reset.
REQ-016 Full-queue acceptance SHALL NOT be bypassed by a same-cycle dequeue; data_addr_ok stays 0 while full.
REQ-017 An accepted request's wr, wstrb, addr, wdata SHALL be enqueued; inputs are don't-care afterwards.
REQ-018 Requests SHALL complete strictly in acceptance order, each producing exactly one data_data_ok pulse.
REQ-019 Word index SHALL be data_addr[log2(MEM_WORDS)+1:2]; higher bits ignored (address wraps modulo MEM_WORDS*4).
REQ-020 A head entry SHALL be serviced LATENCY cycles after it becomes head; request accepted at edge of cycle T into an empty queue SHALL pulse data_data_ok in cycle T+LATENCY.
REQ-021 Successive completions SHALL be at least LATENCY cycles apart; with LATENCY=1 back-to-back requests SHALL complete on consecutive cycles.
REQ-022 Write completion SHALL update only byte lanes with wstrb bit set; data_rdata SHALL be 0 on write completions.
REQ-023 Read completion SHALL return the full aligned word; a read queued behind a write to the same word SHALL see the written data.
REQ-024 data_rdata SHALL be 0 whenever data_data_ok is 0.
REQ-025 Queue pointers SHALL wrap modulo QUEUE_DEPTH; occupancy counter distinguishes full from empty.

Reset
REQ-026 While reset is high: data_addr_ok=0, data_data_ok=0, data_rdata=0, queue emptied, service counter cleared.
REQ-027 Reset mid-operation SHALL discard all pending requests without data_data_ok; memory contents SHALL NOT be cleared, and a head write not yet completed SHALL NOT be applied.

Configuration
REQ-028 Macro DATA_MEM_RANDOM_STALL_EN defined: a 16-bit LFSR (seed from package, stepped every cycle out of reset) SHALL additionally gate data_addr_ok with LFSR bit 0 for initiator stall testing.
REQ-029 Macro undefined: no LFSR logic; data_addr_ok exactly per REQ-015.

Structure
REQ-030 Shared package SHALL hold data_size encodings (0/1/2) and the LFSR seed constant (16'hACE1).
REQ-031 Queue SHALL be one sub-module, req_fifo (synchronous, parameterised width/depth, full/empty flags); memory array and service counter live in data_mem_responder.

Verification
REQ-032 LATENCY=2: write addr 0x10, wstrb 4'b1111, wdata 0x12345678 at cycle 0 -> data_data_ok at cycle 2, rdata 0; read addr 0x10 -> rdata 0x12345678.
REQ-033 Partial write wstrb 4'b0010, wdata 0x0000AB00 over word 0x12345678 -> subsequent read returns 0x1234AB78.
REQ-034 Hold data_req high 8 cycles, LATENCY=3, QUEUE_DEPTH=4 -> data_addr_ok drops after 4 accepts, reasserts only after first data_data_ok; 8 in-order completions total.
REQ-035 Write then read of addr 0x20 accepted on consecutive cycles -> read returns new data; address 0x20+MEM_WORDS*4 aliases to same word.
REQ-036 Assert reset with 3 requests pending -> no data_data_ok after reset; pending write absent from memory; earlier completed writes still readable.
REQ-037 DATA_MEM_RANDOM_STALL_EN defined, 100 random requests -> every accepted request completes exactly once, in order, with scoreboard-matching data.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data memory responder and its request queue.
// Combinational helpers only; no latency, no backpressure.
package data_mem_responder_pkg;

    typedef enum logic [2:0] {
        SIZE_BYTE = 3'd0,
        SIZE_HALF = 3'd1,
        SIZE_WORD = 3'd2
    } data_size_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef struct packed {
        logic        wr;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    // Fibonacci LFSR, taps 16/14/13/11 (maximal length)
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

endpackage

// File: rtl/data_mem_responder_req_fifo.sv
// Synchronous request queue: head visible combinationally, push/pop same cycle allowed.
// Zero-cycle read of head; push ignored when full, pop ignored when empty.
module req_fifo #(
    parameter int WIDTH = 69,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dat,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_dat   = r_mem[r_rptr];

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_dat;
    end

endmodule

// File: rtl/data_mem_responder.sv
// In-order memory responder: queue of QUEUE_DEPTH requests, each head served after LATENCY cycles.
// Backpressure: data_addr_ok low while queue full; DATA_MEM_RANDOM_STALL_EN adds LFSR stalls.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int MEM_WORDS   = 1024,
    parameter int QUEUE_DEPTH = 4,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [2:0]  data_size,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic [31:0] data_rdata,
    output logic        data_data_ok
);
    localparam int IW = $clog2(MEM_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    req_t           w_in;
    req_t           w_head;
    logic           w_full;
    logic           w_empty;
    logic           w_done;
    logic           w_gate;
    logic [IW-1:0]  w_idx;
    logic [CW-1:0]  r_cnt;
    logic [31:0]    r_mem [MEM_WORDS];
    logic           w_unused_bits;

`ifdef DATA_MEM_RANDOM_STALL_EN
    logic [15:0] r_lfsr;

    always_ff @(posedge clk) begin
        if (reset) r_lfsr <= LFSR_SEED;
        else       r_lfsr <= lfsr_step(r_lfsr);
    end

    assign w_gate = r_lfsr[0];
`else
    assign w_gate = 1'b1;
`endif

    // No bypass: a full queue refuses even if the head retires this cycle
    assign data_addr_ok = data_req && !w_full && !reset && w_gate;

    assign w_in = '{wr: data_wr, wstrb: data_wstrb, addr: data_addr, wdata: data_wdata};

    req_fifo #(
        .WIDTH ($bits(req_t)),
        .DEPTH (QUEUE_DEPTH)
    ) u_req_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (data_addr_ok),
        .i_dat   (w_in),
        .i_pop   (w_done),
        .o_dat   (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_idx  = w_head.addr[IW+1:2];
    assign w_done = !w_empty && !reset && (r_cnt == CW'(LATENCY - 1));

    always_ff @(posedge clk) begin
        if (reset || w_done) r_cnt <= '0;
        else if (!w_empty)   r_cnt <= r_cnt + 1'b1;
    end

    // Backing store is never reset; writes land only at completion
    always_ff @(posedge clk) begin
        if (w_done && w_head.wr) begin
            for (int b = 0; b < 4; b++) begin
                if (w_head.wstrb[b]) r_mem[w_idx][8*b +: 8] <= w_head.wdata[8*b +: 8];
            end
        end
    end

    assign data_data_ok = w_done;
    assign data_rdata   = (w_done && !w_head.wr) ? r_mem[w_idx] : 32'h0;

    assign w_unused_bits = ^{data_size, w_head.addr};

endmodule
